fft_stage_router_pipe: RTL and testbench
========================================

// Module: fft_stage_router_pipe
// PURPOSE
// - Registered, parametrised routing network for an N-point radix-2 DIT FFT (N = 2**LOG2N).
// - Sits between the sample/butterfly bank outputs and the butterfly inputs.
// - Stage 0 applies the bit-reverse input ordering.
// - Stage s (s >= 1) applies the pair-interleave that feeds the butterflies of that stage.
// - Adds a valid/ready pipeline register, an auto stage sequencer and an illegal-stage flag.
// PARAMETERS
// - WIDTH  16  bits per real or imaginary sample
// - LOG2N  5   log2 of FFT points; N = 2**LOG2N, LOG2N >= 2; legal stages are 0..LOG2N-1
// - STG_W  3   stage index width; must satisfy 2**STG_W >= LOG2N
// PORTS
// - CLK           in   1          rising-edge clock
// - RST           in   1          asynchronous reset, active-high
// - in_real       in   N*WIDTH    real samples; element k is in_real[k*WIDTH +: WIDTH]
// - in_imag       in   N*WIDTH    imaginary samples, same packing as in_real
// - in_stage      in   STG_W      manual stage select, used when stage_auto=0
// - stage_auto    in   1          1: stage is taken from the internal counter
// - sync_clr      in   1          synchronous clear of the stage counter
// - in_valid      in   1          input beat valid
// - in_ready      out  1          block can accept a beat
// - out_real      out  N*WIDTH    routed real samples
// - out_imag      out  N*WIDTH    routed imaginary samples
// - out_stage     out  STG_W      stage applied to the current output beat
// - out_last      out  1          out_stage == LOG2N-1
// - out_err       out  1          beat carried an illegal stage; its data is forced to zero
// - out_valid     out  1          output beat valid
// - out_ready     in   1          downstream accepts the output beat
// BEHAVIOUR
// - Reset: every output register clears to 0, out_valid=0, stage counter=0.
// - in_ready=1 is the only non-zero value during reset.
// - Handshake:
//   - in_ready = !out_valid || out_ready.
//   - Accept when in_valid && in_ready; data, stage and err register on that edge.
//   - Latency is 1 cycle; full throughput of one beat per clock.
// - Output hold: while out_valid && !out_ready, all out_* hold stable.
// - out_valid falls after a transfer with no new accept.
// - Stage select: stg = stage_auto ? (sync_clr ? 0 : cnt) : in_stage.
// - Routing, k = 0..N-1:
//   - stg==0: out[k] = in[bitrev_LOG2N(k)].
//   - stg=s, 1..LOG2N-1, with H = 2**s and G = 2H; for group g and j < H:
//     - out[g*G+2j]   = in[g*G+j]
//     - out[g*G+2j+1] = in[g*G+j+H]
//   - stg >= LOG2N: out_real = out_imag = 0, out_err = 1.
//   - The same mapping applies to real and imaginary samples.
// - Stage counter cnt:
//   - Advances only on an accepted beat with stage_auto=1.
//   - cnt == LOG2N-1 wraps to 0; otherwise cnt+1.
//   - sync_clr with no accept: cnt <- 0.
//   - sync_clr with an accept: the beat uses stage 0, then cnt <- 1 (sync_clr has priority).
//   - Manual beats, stage_auto=0, leave cnt unchanged.
// - Reset mid-operation: a pending output beat is dropped and the counter returns to 0.
// - No arithmetic; samples pass bit-exact.
// CONFIGURATION
// - FFT_ROUTE_INVERSE_EN defined:
//   - Adds port inv (in, 1), sampled with the beat.
//   - inv=1 applies the inverse map (de-interleave): out[g*G+j] = in[g*G+2j] and out[g*G+j+H] = in[g*G+2j+1].
//   - Stage 0 stays bit-reverse, which is its own inverse.
// - FFT_ROUTE_INVERSE_EN undefined: no inv port; forward map only.
// TESTING  (WIDTH=16, LOG2N=5, in_real[k]=k, in_imag[k]=100+k)
// - Manual stage 0, out_ready=1 -> next cycle out_valid=1.
//   - out_real[1]=16, [3]=24, [16]=1, [31]=31; out_imag[1]=116.
// - Manual stages 1 and 4:
//   - stage 1 -> out_real[0..7] = 0,2,1,3,4,6,5,7.
//   - stage 4 -> out_real[0..3] = 0,16,1,17; out_real[31]=31.
// - Auto mode, 6 back-to-back beats:
//   - out_stage = 0,1,2,3,4,0; out_last=1 only on stage 4.
//   - sync_clr on beat 3 -> that beat has stage 0 and the next beat has stage 1.
// - Backpressure:
//   - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0.
//   - Output held bit-stable, no counter advance.
//   - Release -> next beat follows with no loss or duplication.
// - Illegal stage 5 and 7, manual -> out_err=1, out_real=out_imag=0; next legal beat has out_err=0.
// - RST asserted mid-stream with out_valid=1:
//   - Immediately out_valid=0 and outputs 0.
//   - After release, the first auto beat has out_stage=0.
// - FFT_ROUTE_INVERSE_EN defined: stage s forward then stage s with inv=1 -> original data restored, s=1..4.

Source files
------------

// File: rtl/fft_stage_router_pipe.sv
// rtl/fft_stage_router_pipe.sv - registered radix-2 DIT FFT stage routing network
//
// Purpose
//   Routes N = 2**LOG2N complex samples between the sample/butterfly bank
//   outputs and the butterfly inputs of an FFT datapath.
//     stage 0        : bit-reverse input ordering
//     stage s >= 1   : pair-interleave feeding the butterflies of stage s
//     stage >= LOG2N : illegal, data forced to zero and out_err raised
//   One valid/ready output register gives 1-cycle latency at full throughput.
//   An internal stage counter can sequence stages automatically.
//
// Optional feature (macro FFT_ROUTE_INVERSE_EN)
//   Adds input inv; inv=1 applies the de-interleave (inverse) map for
//   stages >= 1. Stage 0 is its own inverse and is unaffected.
//
// Ports
//   CLK, RST      clock, asynchronous active-high reset
//   in_real/imag  N packed samples, element k at [k*WIDTH +: WIDTH]
//   in_stage      manual stage select (stage_auto=0)
//   stage_auto    take the stage from the internal counter
//   sync_clr      synchronous clear of the stage counter
//   in_valid      input beat valid
//   in_ready      block can accept a beat
//   inv           inverse map select (FFT_ROUTE_INVERSE_EN only)
//   out_real/imag routed samples
//   out_stage     stage applied to the current output beat
//   out_last      out_stage == LOG2N-1
//   out_err       beat carried an illegal stage
//   out_valid     output beat valid
//   out_ready     downstream accepts the output beat

module fft_stage_router_pipe #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 5,
    parameter int STG_W = 3
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [(2**LOG2N)*WIDTH-1:0]    in_real,
    input  logic [(2**LOG2N)*WIDTH-1:0]    in_imag,
    input  logic [STG_W-1:0]               in_stage,
    input  logic                           stage_auto,
    input  logic                           sync_clr,
    input  logic                           in_valid,
    output logic                           in_ready,
`ifdef FFT_ROUTE_INVERSE_EN
    input  logic                           inv,
`endif
    output logic [(2**LOG2N)*WIDTH-1:0]    out_real,
    output logic [(2**LOG2N)*WIDTH-1:0]    out_imag,
    output logic [STG_W-1:0]               out_stage,
    output logic                           out_last,
    output logic                           out_err,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int N    = 2**LOG2N;
    localparam int DW   = N*WIDTH;

    localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N-1);
    localparam logic [STG_W-1:0] STG_ONE  = STG_W'(1);

    // Source index for output element k at stage s.
    // For s >= 1 the map only permutes the low s+1 index bits (one group of
    // G = 2**(s+1) elements): the forward interleave is a rotate-right of
    // those bits by one, the inverse is a rotate-left by one.
    function automatic logic [LOG2N-1:0] src_index(
        input logic [LOG2N-1:0] k,
        input logic [STG_W-1:0] s,
        input logic             inv_map
    );
        logic [LOG2N-1:0] r;
        logic [LOG2N-1:0] mask;
        logic [LOG2N-1:0] low;
        logic [LOG2N-1:0] rot;
        r    = '0;
        mask = '0;
        low  = '0;
        rot  = '0;
        if (s == '0) begin
            for (int b = 0; b < LOG2N; b++) begin
                r[b] = k[LOG2N-1-b];
            end
        end else begin
            mask = LOG2N'((1 << (int'(s) + 1)) - 1);
            low  = k & mask;
            if (!inv_map) begin
                rot = (low >> 1) | LOG2N'(int'(low[0]) << int'(s));
            end else begin
                rot = ((low << 1) & mask) | (low >> s);
            end
            r = (k & ~mask) | rot;
        end
        return r;
    endfunction

    // Inverse select
    logic inv_sel;
`ifdef FFT_ROUTE_INVERSE_EN
    assign inv_sel = inv;
`else
    assign inv_sel = 1'b0;
`endif

    // State
    logic [STG_W-1:0] cnt_q,   cnt_d;
    logic [DW-1:0]    real_q,  real_d;
    logic [DW-1:0]    imag_q,  imag_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic             err_q,   err_d;
    logic             valid_q, valid_d;

    // Handshake and stage selection
    logic             accept;
    logic [STG_W-1:0] stg;
    logic             stg_err;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        stg = in_stage;
        if (stage_auto) begin
            stg = sync_clr ? '0 : cnt_q;
        end
    end

    assign stg_err = (int'(stg) >= LOG2N);

    // Routing network
    logic [DW-1:0]    route_real;
    logic [DW-1:0]    route_imag;
    logic [LOG2N-1:0] src;

    always_comb begin
        route_real = '0;
        route_imag = '0;
        src        = '0;
        for (int k = 0; k < N; k++) begin
            src = src_index(LOG2N'(k), stg, inv_sel);
            if (!stg_err) begin
                route_real[k*WIDTH +: WIDTH] = in_real[int'(src)*WIDTH +: WIDTH];
                route_imag[k*WIDTH +: WIDTH] = in_imag[int'(src)*WIDTH +: WIDTH];
            end
        end
    end

    // Stage counter: an auto beat taken with sync_clr runs as stage 0, so
    // the counter lands on 1 for the following beat.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && stage_auto) begin
            if (sync_clr) begin
                cnt_d = STG_ONE;
            end else if (cnt_q == STG_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + STG_ONE;
            end
        end else if (sync_clr) begin
            cnt_d = '0;
        end
    end

    // Output register next state: load on accept, otherwise hold data and
    // drop valid once the downstream has taken the beat.
    always_comb begin
        real_d  = real_q;
        imag_d  = imag_q;
        stage_d = stage_q;
        err_d   = err_q;
        valid_d = valid_q;
        if (accept) begin
            real_d  = route_real;
            imag_d  = route_imag;
            stage_d = stg;
            err_d   = stg_err;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            real_q  <= '0;
            imag_q  <= '0;
            stage_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            real_q  <= real_d;
            imag_q  <= imag_d;
            stage_q <= stage_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign out_real  = real_q;
    assign out_imag  = imag_q;
    assign out_stage = stage_q;
    assign out_last  = (stage_q == STG_LAST);
    assign out_err   = err_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fft_stage_router_pipe.sv
// tb/tb_fft_stage_router_pipe.sv - directed self-checking bench for fft_stage_router_pipe

module tb_fft_stage_router_pipe;

    localparam int WIDTH = 16;
    localparam int LOG2N = 5;
    localparam int STG_W = 3;
    localparam int N     = 2**LOG2N;
    localparam int DW    = N*WIDTH;

    logic             CLK = 1'b0;
    logic             RST;
    logic [DW-1:0]    in_real;
    logic [DW-1:0]    in_imag;
    logic [STG_W-1:0] in_stage;
    logic             stage_auto;
    logic             sync_clr;
    logic             in_valid;
    logic             in_ready;
    logic             inv;
    logic [DW-1:0]    out_real;
    logic [DW-1:0]    out_imag;
    logic [STG_W-1:0] out_stage;
    logic             out_last;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] orig_real;
    logic [DW-1:0] orig_imag;

    always #5 CLK = ~CLK;

    fft_stage_router_pipe #(.WIDTH(WIDTH), .LOG2N(LOG2N), .STG_W(STG_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .in_stage   (in_stage),
        .stage_auto (stage_auto),
        .sync_clr   (sync_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef FFT_ROUTE_INVERSE_EN
        .inv        (inv),
`endif
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_stage  (out_stage),
        .out_last   (out_last),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] elem(input logic [DW-1:0] v, input int k);
        return 32'(v[k*WIDTH +: WIDTH]);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            orig_real[k*WIDTH +: WIDTH] = 16'(k);
            orig_imag[k*WIDTH +: WIDTH] = 16'(100 + k);
        end
        in_real    = orig_real;
        in_imag    = orig_imag;
        in_stage   = '0;
        stage_auto = 1'b0;
        sync_clr   = 1'b0;
        in_valid   = 1'b0;
        inv        = 1'b0;
        out_ready  = 1'b1;
        RST        = 1'b1;

        step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_zero",  32'(out_real == '0 && out_imag == '0), 1);
        check("rst_stage", 32'(out_stage), 0);
        RST = 1'b0;
        step();

        // Manual stage 0: bit reverse
        in_valid = 1'b1;
        in_stage = 3'd0;
        step();
        check("s0_valid", 32'(out_valid), 1);
        check("s0_r1",  elem(out_real, 1), 16);
        check("s0_r3",  elem(out_real, 3), 24);
        check("s0_r16", elem(out_real, 16), 1);
        check("s0_r31", elem(out_real, 31), 31);
        check("s0_i1",  elem(out_imag, 1), 116);

        // Manual stage 1
        in_stage = 3'd1;
        step();
        begin
            int exp1 [8] = '{0, 2, 1, 3, 4, 6, 5, 7};
            for (int k = 0; k < 8; k++) begin
                check($sformatf("s1_r%0d", k), elem(out_real, k), 32'(exp1[k]));
            end
        end
        check("s1_last", 32'(out_last), 0);

        // Manual stage 4
        in_stage = 3'd4;
        step();
        check("s4_r0",  elem(out_real, 0), 0);
        check("s4_r1",  elem(out_real, 1), 16);
        check("s4_r2",  elem(out_real, 2), 1);
        check("s4_r3",  elem(out_real, 3), 17);
        check("s4_r31", elem(out_real, 31), 31);
        check("s4_i1",  elem(out_imag, 1), 116);
        check("s4_last", 32'(out_last), 1);

        // Illegal stages
        in_stage = 3'd5;
        step();
        check("ill5_err",  32'(out_err), 1);
        check("ill5_zero", 32'(out_real == '0 && out_imag == '0), 1);
        check("ill5_stg",  32'(out_stage), 5);
        in_stage = 3'd7;
        step();
        check("ill7_err",  32'(out_err), 1);
        check("ill7_zero", 32'(out_real == '0 && out_imag == '0), 1);
        in_stage = 3'd2;
        step();
        check("leg_err", 32'(out_err), 0);
        check("leg_stg", 32'(out_stage), 2);
        check("leg_r1",  elem(out_real, 1), 4);

        // Auto mode, six back-to-back beats
        stage_auto = 1'b1;
        begin
            int exps [6] = '{0, 1, 2, 3, 4, 0};
            for (int i = 0; i < 6; i++) begin
                step();
                check($sformatf("auto%0d_stg", i), 32'(out_stage), 32'(exps[i]));
                check($sformatf("auto%0d_last", i), 32'(out_last), (exps[i] == 4) ? 1 : 0);
                check($sformatf("auto%0d_valid", i), 32'(out_valid), 1);
            end
        end

        // sync_clr on the third beat of a fresh run (counter now 1)
        step();
        check("clr_b1", 32'(out_stage), 1);
        step();
        check("clr_b2", 32'(out_stage), 2);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("clr_b3", 32'(out_stage), 0);
        step();
        check("clr_b4", 32'(out_stage), 1);
        check("clr_b4_r1", elem(out_real, 1), 2);

        // Backpressure: counter at 2, stage-1 beat on the output
        out_ready = 1'b0;
        #1;
        check("bp_ready0", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("bp%0d_stg", i), 32'(out_stage), 1);
            check($sformatf("bp%0d_r1", i), elem(out_real, 1), 2);
            check($sformatf("bp%0d_rdy", i), 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_rel_stg", 32'(out_stage), 2);
        check("bp_rel_r1",  elem(out_real, 1), 4);
        step();
        check("bp_next_stg", 32'(out_stage), 3);

        // Asynchronous reset mid-stream
        #2;
        RST = 1'b1;
        #1;
        check("mrst_valid", 32'(out_valid), 0);
        check("mrst_zero",  32'(out_real == '0 && out_imag == '0), 1);
        check("mrst_stg",   32'(out_stage), 0);
        check("mrst_ready", 32'(in_ready), 1);
        #1;
        RST = 1'b0;
        step();
        check("post_rst_stg",   32'(out_stage), 0);
        check("post_rst_valid", 32'(out_valid), 1);

        // Valid falls after a transfer with no new accept
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 0);

`ifdef FFT_ROUTE_INVERSE_EN
        stage_auto = 1'b0;
        for (int s = 1; s < LOG2N; s++) begin
            in_valid = 1'b1;
            in_stage = STG_W'(s);
            inv      = 1'b0;
            in_real  = orig_real;
            in_imag  = orig_imag;
            step();
            in_real  = out_real;
            in_imag  = out_imag;
            inv      = 1'b1;
            step();
            check($sformatf("inv_s%0d_real", s), 32'(out_real == orig_real), 1);
            check($sformatf("inv_s%0d_imag", s), 32'(out_imag == orig_imag), 1);
        end
        in_valid = 1'b0;
        inv      = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
